// File: rtl/seq_mul_8bit.sv
// 8x8 unsigned sequential multiplier, shift-and-add LSB first, 16-bit result.
// One multiply takes eight CALC cycles plus one DONE cycle; results back-to-back every 9 cycles.
module seq_mul_8bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state_o
);

  // Handshake: start is taken on a rising edge only in IDLE or DONE (a/b captured
  // there); busy marks the 8 CALC cycles; done is a 1-cycle pulse with product valid,
  // and product holds until the next completion.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  mcand_q;
  logic [7:0]  mplier_q;
  logic [2:0]  cnt_q;
  logic [15:0] acc_q;
  logic [15:0] product_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] addend_d;
  logic [15:0] acc_d;

  always_comb begin
    addend_d = 16'h0000;
    if (mplier_q[cnt_q]) begin
      addend_d = {8'h00, mcand_q} << cnt_q;
    end
    acc_d = acc_q + addend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= 8'h00;
      mplier_q  <= 8'h00;
      cnt_q     <= 3'd0;
      acc_q     <= 16'h0000;
      product_q <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= 16'h0000;
            cnt_q    <= 3'd0;
            busy_q   <= 1'b1;
            state_q  <= ST_CALC;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 3'd1;
          // The counter's wrap from 7 marks the last iteration.
          if (cnt_q == 3'd7) begin
            product_q <= acc_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign product     = product_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_mul_8bit.sv
// Scoreboard bench for seq_mul_8bit: driver pushes expected products, a negedge
// monitor pops them on every done pulse and checks busy/done timing.
module tb_seq_mul_8bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  logic [15:0] exp_q[$];
  int checks;
  int errors;

  seq_mul_8bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .product     (product),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [7:0] av, input logic [7:0] bv);
    @(posedge clk);
    #1;
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(16'(av) * 16'(bv));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic mul(input logic [7:0] av, input logic [7:0] bv);
    issue(av, bv);
    drain();
  endtask

  // scoreboard monitor
  logic [15:0] prev_product;
  logic        prev_busy;
  logic        prev_done;
  int          run_cnt;
  int          last_run;

  initial begin
    prev_product = 16'h0;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    run_cnt = 0;
    last_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_cnt = 0;
        last_run = 0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        prev_product = product;
      end else begin
        if (busy) run_cnt++;
        else if (prev_busy) begin
          last_run = run_cnt;
          run_cnt = 0;
        end
        if (busy) chk("product_stable_in_calc", {16'd0, product}, {16'd0, prev_product});
        if (done) begin
          chk("busy_done_exclusive", {31'd0, busy}, 32'd0);
          chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
          chk("busy_run_len", last_run, 32'd8);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: product 0x%0h with no outstanding request", product);
          end else begin
            chk("product", {16'd0, product}, {16'd0, exp_q.pop_front()});
          end
        end
        prev_busy = busy;
        prev_done = done;
        prev_product = product;
      end
    end
  end

  // stimulus
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    #1;
    chk("reset_product", {16'd0, product}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    mul(8'h0D, 8'h0B);
    chk("hold_0x8f", {16'd0, product}, 32'h008F);
    mul(8'hFF, 8'hFF);
    chk("hold_0xfe01", {16'd0, product}, 32'hFE01);
    mul(8'h00, 8'hA5);
    chk("hold_zero", {16'd0, product}, 32'h0000);
    mul(8'h01, 8'hFF);
    mul(8'hFF, 8'h01);
    mul(8'h80, 8'h80);
    mul(8'hA5, 8'h00);

    // start held through CALC; operands changed mid-CALC must be ignored,
    // then the DONE-cycle edge accepts the new operands
    @(posedge clk);
    #1;
    a = 8'h10;
    b = 8'h10;
    start = 1'b1;
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0006);
    @(posedge clk);
    #1;
    a = 8'h02;
    b = 8'h03;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_second_busy", {31'd0, busy}, 32'd1);
    chk("b2b_first_hold", {16'd0, product}, 32'h0100);
    drain();
    chk("b2b_second_hold", {16'd0, product}, 32'h0006);

    // asynchronous reset during the 4th CALC cycle aborts with no done pulse
    @(posedge clk);
    #1;
    a = 8'h33;
    b = 8'h44;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_product", {16'd0, product}, 32'h0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_product_after", {16'd0, product}, 32'h0);
    mul(8'h0D, 8'h0B);

    for (int i = 0; i < 1000; i++) begin
      mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mul_8bit.md
SEQ_MUL_8BIT -- requirements
Module: seq_mul_8bit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL expose clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL expose rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL expose start, input, 1 bit: request to begin a multiply, sampled on the clk rising edge.
REQ-005 SHALL expose a, input, 8 bits: unsigned multiplicand, sampled only when start is accepted.
REQ-006 SHALL expose b, input, 8 bits: unsigned multiplier, sampled only when start is accepted.
REQ-007 SHALL expose product, output, 16 bits: last completed result; the downstream 8-bit 2:1 mux selects between product[7:0] and product[15:8].
REQ-008 SHALL expose busy, output, 1 bit: high while a multiply is in progress.
REQ-009 SHALL expose done, output, 1 bit: one-cycle pulse marking a new valid product.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-011 SHALL accept start only in IDLE or DONE; the accepting edge is E0.
REQ-012 SHALL latch a and b at E0, clear the internal 16-bit accumulator, load an iteration counter with 0, and move to CALC.
REQ-013 SHALL ignore start while in CALC: no operand re-latch, no restart, no effect on the counter.
REQ-014 In CALC, at each edge SHALL add (multiplicand << counter) to the accumulator if multiplier bit[counter] is 1 (shift-and-add, LSB first), then increment the counter.
REQ-015 SHALL perform exactly 8 CALC iterations at edges E1..E8; the counter is 3 bits and its wrap from 7 to 0 ends CALC.
REQ-016 SHALL keep all additions 16 bits wide with no truncation; the maximum result 255*255 = 65025 (0xFE01) SHALL be exact.
REQ-017 At E8 SHALL load product with the final accumulator value and enter DONE.
REQ-018 busy SHALL be high for exactly the 8 cycles following E0 (E0..E8) and low otherwise.
REQ-019 done SHALL be high only in the cycle following E8, for exactly one cycle.
REQ-020 DONE SHALL return to IDLE at the next edge if start is low, or accept a new start (REQ-012) if start is high; back-to-back multiplies therefore take 9 cycles each.
REQ-021 product SHALL hold its value from E8 until the next E8 and SHALL NOT change during CALC.
REQ-022 A zero operand SHALL still take the full 8 iterations and produce 0x0000.
REQ-023 busy and done SHALL never be high in the same cycle.

Reset
REQ-024 rst_n low SHALL immediately, without waiting for clk, force the FSM to IDLE, product to 0x0000, busy to 0, done to 0, and the counter and accumulator to 0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow, and product SHALL read 0x0000.
REQ-026 After rst_n deasserts, start SHALL be accepted at the first rising edge at which it is high.

Verification
REQ-027 Bench SHALL cover: a=0x0D, b=0x0B, start for 1 cycle -> busy high 8 cycles, done pulse 9 edges after E0, product=0x008F.
REQ-028 Bench SHALL cover: a=0xFF, b=0xFF -> product=0xFE01; and a=0x00, b=0xA5 -> product=0x0000 with the full 9-cycle latency.
REQ-029 Bench SHALL cover: start held high and a/b changed to 0x02/0x03 during CALC of 0x10*0x10 -> product=0x0100, with a second multiply starting in the DONE cycle that yields 0x0006 nine cycles later.
REQ-030 Bench SHALL cover: rst_n pulsed low between clock edges at the 4th CALC cycle -> busy=0 and product=0x0000 immediately, and no done pulse for the aborted multiply.
REQ-031 Bench SHALL cover: a randomized sweep of 1000 operand pairs -> product == a*b on every done pulse, and busy and done never high together.
